// File: rtl/vga_write_scheduler.sv
// vga_write_scheduler: owns the single video-memory write port. Two pixel
// requesters are served round-robin, and a full-screen clear sequencer can
// take over the port to sweep every dot with a background colour.
module vga_write_scheduler #(
  parameter int X_DOTS = 320,
  parameter int Y_DOTS = 240,
  parameter int XW     = 9,
  parameter int YW     = 8,
  parameter int CW     = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          req0,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [CW-1:0] c0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] c1,
  output logic          gnt1,
  input  logic          clear_start,
  input  logic [CW-1:0] clear_colour,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_colour,
  output logic          plot
);

  localparam logic [XW-1:0] X_LAST = XW'(X_DOTS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_DOTS - 1);

  typedef enum logic [1:0] {SERVE, CLEAR, DONE} state_t;

  state_t        state, state_next;

  // prio=0 favours requester 0, prio=1 favours requester 1
  logic          prio, prio_d;
  logic [XW-1:0] cnt_x, cnt_x_d;
  logic [YW-1:0] cnt_y, cnt_y_d;
  logic [CW-1:0] bg, bg_d;

  logic          gnt0_d, gnt1_d, plot_d, busy_d, done_d;
  logic [XW-1:0] plot_x_d;
  logic [YW-1:0] plot_y_d;
  logic [CW-1:0] plot_colour_d;

  logic          elig0, elig1, pick0, pick1;
  logic          in_range0, in_range1, sweep_last;

  // A requester granted this cycle sits out the next edge, so a grant never
  // repeats back-to-back for the same write.
  assign elig0      = req0 & ~gnt0;
  assign elig1      = req1 & ~gnt1;
  assign pick1      = elig1 & (~elig0 | prio);
  assign pick0      = elig0 & ~pick1;
  assign in_range0  = (int'(x0) < X_DOTS) && (int'(y0) < Y_DOTS);
  assign in_range1  = (int'(x1) < X_DOTS) && (int'(y1) < Y_DOTS);
  assign sweep_last = (cnt_x == X_LAST) && (cnt_y == Y_LAST);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= SERVE;
    else         state <= state_next;
  end

  // Next-state logic: a clear preempts serving; the sweep ends on the last dot
  always_comb begin
    state_next = state;
    case (state)
      SERVE:   if (clear_start) state_next = CLEAR;
      CLEAR:   if (sweep_last)  state_next = DONE;
      DONE:    state_next = SERVE;
      default: state_next = SERVE;
    endcase
  end

  // Output/datapath next values; everything below is registered on one edge
  always_comb begin
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    plot_d        = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    plot_x_d      = plot_x;
    plot_y_d      = plot_y;
    plot_colour_d = plot_colour;
    prio_d        = prio;
    cnt_x_d       = cnt_x;
    cnt_y_d       = cnt_y;
    bg_d          = bg;
    case (state)
      SERVE: begin
        if (clear_start) begin
          bg_d    = clear_colour;
          cnt_x_d = '0;
          cnt_y_d = '0;
          busy_d  = 1'b1;
        end else if (pick0) begin
          gnt0_d        = 1'b1;
          plot_d        = in_range0;
          plot_x_d      = x0;
          plot_y_d      = y0;
          plot_colour_d = c0;
          prio_d        = 1'b1;
        end else if (pick1) begin
          gnt1_d        = 1'b1;
          plot_d        = in_range1;
          plot_x_d      = x1;
          plot_y_d      = y1;
          plot_colour_d = c1;
          prio_d        = 1'b0;
        end
      end
      CLEAR: begin
        busy_d        = 1'b1;
        plot_d        = 1'b1;
        plot_x_d      = cnt_x;
        plot_y_d      = cnt_y;
        plot_colour_d = bg;
        if (cnt_x == X_LAST) begin
          cnt_x_d = '0;
          cnt_y_d = cnt_y + 1'b1;
        end else begin
          cnt_x_d = cnt_x + 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset clears everything including the latch
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      plot        <= 1'b0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      prio        <= 1'b0;
      cnt_x       <= '0;
      cnt_y       <= '0;
      bg          <= '0;
    end else begin
      gnt0        <= gnt0_d;
      gnt1        <= gnt1_d;
      plot        <= plot_d;
      clear_busy  <= busy_d;
      clear_done  <= done_d;
      plot_x      <= plot_x_d;
      plot_y      <= plot_y_d;
      plot_colour <= plot_colour_d;
      prio        <= prio_d;
      cnt_x       <= cnt_x_d;
      cnt_y       <= cnt_y_d;
      bg          <= bg_d;
    end
  end

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Scoreboard bench for vga_write_scheduler: stimulus pushes the expected
// output events (with their cycle), a monitor pops and compares them.
module tb_vga_write_scheduler;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [8:0] x0 = '0, x1 = '0;
  logic [7:0] y0 = '0, y1 = '0;
  logic [2:0] c0 = '0, c1 = '0;
  logic       gnt0, gnt1;
  logic       clear_start = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       clear_busy, clear_done;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot;

  vga_write_scheduler dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .x0(x0), .y0(y0), .c0(c0), .gnt0(gnt0),
    .req1(req1), .x1(x1), .y1(y1), .c1(c1), .gnt1(gnt1),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot(plot)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       g0, g1, p, busy, done, chk;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   n, k;

  function automatic void push(input int cy, input logic g0, input logic g1,
                               input logic p, input logic busy, input logic done,
                               input logic chk, input logic [8:0] x,
                               input logic [7:0] y, input logic [2:0] c);
    exp_t e;
    e.cyc = cy; e.g0 = g0; e.g1 = g1; e.p = p; e.busy = busy; e.done = done;
    e.chk = chk; e.x = x; e.y = y; e.c = c;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: flag expected events whose cycle passed, then compare any activity
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_event at cyc=%0d required_cyc=%0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (gnt0 || gnt1 || plot || clear_done) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d gnt0=%b gnt1=%b plot=%b done=%b required=none",
                 cyc, gnt0, gnt1, plot, clear_done);
      end else begin
        me = q.pop_front();
        if (cyc != me.cyc || gnt0 !== me.g0 || gnt1 !== me.g1 || plot !== me.p ||
            clear_busy !== me.busy || clear_done !== me.done ||
            (me.chk && (plot_x !== me.x || plot_y !== me.y || plot_colour !== me.c))) begin
          fails++;
          $display("FAIL event cyc=%0d g0=%b g1=%b p=%b busy=%b done=%b xyc=%0d,%0d,%0d required cyc=%0d g0=%b g1=%b p=%b busy=%b done=%b xyc=%0d,%0d,%0d",
                   cyc, gnt0, gnt1, plot, clear_busy, clear_done, plot_x, plot_y, plot_colour,
                   me.cyc, me.g0, me.g1, me.p, me.busy, me.done, me.x, me.y, me.c);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 32'({gnt0, gnt1, plot, clear_busy, clear_done, plot_x, plot_y, plot_colour}), 32'd0);
    resetn = 1'b1;
    tick(); tick();
    check("idle_after_reset", 32'({gnt0, gnt1, plot, clear_busy, clear_done, plot_x, plot_y, plot_colour}), 32'd0);

    // Lone requester 0: grant one cycle later, then every second cycle
    n = cyc;
    req0 = 1'b1; x0 = 9'd5; y0 = 8'd7; c0 = 3'b101;
    push(n + 1, 1, 0, 1, 0, 0, 1, 9'd5, 8'd7, 3'b101);
    push(n + 3, 1, 0, 1, 0, 0, 1, 9'd5, 8'd7, 3'b101);
    push(n + 5, 1, 0, 1, 0, 0, 1, 9'd5, 8'd7, 3'b101);
    repeat (5) tick();
    req0 = 1'b0;
    repeat (3) tick();

    // Fresh reset so the pointer favours requester 0 again
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // Both requesters continuously: strict alternation starting with 0
    n = cyc;
    req0 = 1'b1; x0 = 9'd10; y0 = 8'd20; c0 = 3'b010;
    req1 = 1'b1; x1 = 9'd30; y1 = 8'd40; c1 = 3'b110;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(n + 1 + i, 1, 0, 1, 0, 0, 1, 9'd10, 8'd20, 3'b010);
      else            push(n + 1 + i, 0, 1, 1, 0, 0, 1, 9'd30, 8'd40, 3'b110);
    end
    repeat (6) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();

    // x out of range: granted, not plotted
    n = cyc;
    req1 = 1'b1; x1 = 9'd320; y1 = 8'd10; c1 = 3'b011;
    push(n + 1, 0, 1, 0, 0, 0, 0, '0, '0, '0);
    tick();
    req1 = 1'b0;
    repeat (2) tick();

    // y out of range: granted, not plotted
    n = cyc;
    req0 = 1'b1; x0 = 9'd0; y0 = 8'd240; c0 = 3'b111;
    push(n + 1, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    tick();
    req0 = 1'b0;
    repeat (2) tick();

    // Last valid dot is plotted, then fields hold while idle
    n = cyc;
    req1 = 1'b1; x1 = 9'd319; y1 = 8'd239; c1 = 3'b101;
    push(n + 1, 0, 1, 1, 0, 0, 1, 9'd319, 8'd239, 3'b101);
    tick();
    req1 = 1'b0;
    repeat (3) tick();
    check("hold_plot_x", 32'(plot_x), 32'd319);
    check("hold_plot_y", 32'(plot_y), 32'd239);

    // Full clear with a competing request and a second start mid-sweep
    n = cyc;
    clear_start = 1'b1; clear_colour = 3'b001;
    req0 = 1'b1; x0 = 9'd1; y0 = 8'd2; c0 = 3'b100;
    k = n + 1;
    for (int i = 0; i < 76800; i++)
      push(k + 1 + i, 0, 0, 1, 1, 0, 1, 9'(i % 320), 8'(i / 320), 3'b001);
    push(k + 76801, 0, 0, 0, 0, 1, 0, '0, '0, '0);
    push(k + 76802, 1, 0, 1, 0, 0, 1, 9'd1, 8'd2, 3'b100);
    tick();
    clear_start = 1'b0;
    check("busy_rise", 32'(clear_busy), 32'd1);
    check("no_gnt_on_start", 32'({gnt0, gnt1}), 32'd0);
    repeat (500) tick();
    clear_start = 1'b1; clear_colour = 3'b110;
    tick();
    clear_start = 1'b0;
    repeat (k + 76802 - cyc) tick();
    req0 = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a sweep
    clear_start = 1'b1; clear_colour = 3'b011;
    tick();
    clear_start = 1'b0;
    k = cyc;
    for (int i = 0; i < 1000; i++)
      push(k + 1 + i, 0, 0, 1, 1, 0, 1, 9'(i % 320), 8'(i / 320), 3'b011);
    repeat (1000) tick();
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", 32'({gnt0, gnt1, plot, clear_busy, clear_done, plot_x, plot_y, plot_colour}), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    n = cyc;
    req1 = 1'b1; x1 = 9'd100; y1 = 8'd50; c1 = 3'b111;
    push(n + 1, 0, 1, 1, 0, 0, 1, 9'd100, 8'd50, 3'b111);
    tick();
    req1 = 1'b0;
    repeat (5) tick();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_write_scheduler.md
Name: vga_write_scheduler

Overview:
- Owns the single write port into video memory, on the write side of the VGA adapter.
- Arbitrates between two pixel requesters, for example a trace plotter and a grid/cursor overlay, using round-robin.
- Contains a full-screen clear sequencer that sweeps every dot with a background colour.
- Emits x/y/colour/plot strobes in 320x240 dot coordinates, which feed the adapter's address translator on the write path.

Parameters:
- X_DOTS, 320, horizontal dot count; valid x is 0..X_DOTS-1.
- Y_DOTS, 240, vertical dot count; valid y is 0..Y_DOTS-1.
- XW, 9, x coordinate width.
- YW, 8, y coordinate width.
- CW, 3, colour width (3*BITS_PER_COLOUR_CHANNEL).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 write request.
- x0  in  XW  requester 0 x coordinate.
- y0  in  YW  requester 0 y coordinate.
- c0  in  CW  requester 0 colour.
- gnt0  out  1  requester 0 accept pulse.
- req1  in  1  requester 1 write request.
- x1  in  XW  requester 1 x coordinate.
- y1  in  YW  requester 1 y coordinate.
- c1  in  CW  requester 1 colour.
- gnt1  out  1  requester 1 accept pulse.
- clear_start  in  1  single-cycle pulse; starts a full-screen clear.
- clear_colour  in  CW  background colour, sampled on clear_start.
- clear_busy  out  1  high while the sweep is running.
- clear_done  out  1  one-cycle pulse after the last dot is written.
- plot_x  out  XW  write x coordinate.
- plot_y  out  YW  write y coordinate.
- plot_colour  out  CW  write colour.
- plot  out  1  video memory write enable.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Named clock and resetn.
- Reset state: every output is 0, the state is SERVE, and the round-robin pointer favours requester 0.
- Outputs are registered. gntN, plot and the plot_* fields update on the same edge, so a write is visible in the cycle gntN is high.
- Request handshake:
  - A requester holds reqN and its x/y/colour stable until it sees gntN=1.
  - gntN is high for exactly one cycle per accepted write.
  - A requester whose gnt is currently high is not eligible on the next edge. This blocks double-grants, so a lone requester gets at most one write every 2 cycles.
- SERVE state:
  - If exactly one eligible req is high, grant it.
  - If both are eligible, grant the one not served last, then update the pointer.
  - If no req is high, plot=0, the gnts are 0, and plot_* hold their previous values.
- Out-of-range coordinates (x>=X_DOTS or y>=Y_DOTS): the request is still granted (gnt pulses, pointer updates) but plot=0. The write is dropped silently.
- SERVE to CLEAR on clear_start:
  - clear_start has priority over requests in the same cycle, and no gnt is issued.
  - clear_colour is latched.
  - The sweep counters are set to x=0, y=0 and clear_busy=1.
- CLEAR state:
  - plot=1 every cycle; plot_x/plot_y follow the counters and plot_colour is the latched colour.
  - x increments each cycle and wraps to 0 at X_DOTS-1, incrementing y.
  - After (X_DOTS-1, Y_DOTS-1) is written, go to DONE.
  - The sweep takes exactly X_DOTS*Y_DOTS = 76800 plot cycles.
  - No gnts are issued. Requests stay pending and unaffected.
  - clear_start is ignored.
- DONE state: lasts one cycle with clear_done=1, clear_busy=0 and plot=0, then returns to SERVE. Pending requests are arbitrated from the next edge.
- Pointer: unchanged by a clear.
- Reset mid-operation: everything returns to reset values immediately. The sweep is abandoned with no clear_done, and the clear latch resets to 0.

Test Plan:
- After reset, req0=1 (x0=5, y0=7, c0=3'b101) held: gnt0 and plot pulse 1 cycle later with plot_x=5, plot_y=7, colour=101. Further grants follow every 2nd cycle while req0 stays high.
- req0 and req1 both held high continuously: gnt0, gnt1, gnt0, gnt1… on consecutive cycles with plot=1 every cycle. The first grant goes to requester 0.
- req1 with x1=320, y1=10: gnt1 pulses and plot stays 0.
- clear_start with clear_colour=3'b001, with req0 asserted in the same cycle:
  - clear_busy rises on the next edge and no gnt0 is issued.
  - 76800 plot cycles follow, with the first at (0,0) and the last at (319,239), all with colour 001.
  - clear_done pulses once, then gnt0 is issued.
- Second clear_start mid-sweep: no restart; the sweep still completes in 76800 cycles from the first start.
- resetn low at sweep dot 1000: all outputs go to 0 asynchronously and no clear_done is produced. After release, req1 alone is granted normally.
